pipe_ctrl: RTL

- Central pipeline sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
- Merges hazard requests and drives per-register enable/flush controls:
  - load-use stall from the forwarding/hazard unit
  - taken branch resolved in EX
  - instruction- and data-memory wait
  - halt instruction in ID
- Owns a small FSM for multi-cycle memory waits and halt draining, plus stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 71 +++++++
 rtl/pipe_ctrl_sat_counter.sv | 24 ++
 rtl/pipe_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM state encoding,
// the bundled enable/flush control vector and its canned patterns.
package pipe_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  // One bit per pipeline-register control; a flush loads a NOP bubble
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } ctrl_t;

  localparam int DEF_MEM_TIMEOUT = 15;
  localparam int DEF_DRAIN_CYC   = 3;

  // Reset: nothing advances, every bubble-capable register is cleared
  localparam ctrl_t CTRL_RESET = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0,
                                   exmem_en: 1'b0, memwb_en: 1'b0,
                                   ifid_flush: 1'b1, idex_flush: 1'b1,
                                   memwb_flush: 1'b1};

  // Normal flow: every stage advances
  localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                 exmem_en: 1'b1, memwb_en: 1'b1,
                                 ifid_flush: 1'b0, idex_flush: 1'b0,
                                 memwb_flush: 1'b0};

  // Data memory busy: whole pipe frozen, WB gets a bubble so the frozen
  // MEM result is not written back twice
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0,
                                    exmem_en: 1'b0, memwb_en: 1'b0,
                                    ifid_flush: 1'b0, idex_flush: 1'b0,
                                    memwb_flush: 1'b1};

  // Taken branch: redirect PC and squash the two wrong-path instructions
  localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                    exmem_en: 1'b1, memwb_en: 1'b1,
                                    ifid_flush: 1'b1, idex_flush: 1'b1,
                                    memwb_flush: 1'b0};

  // Hold IF/ID, push a bubble into ID/EX, let EX..WB drain forward
  localparam ctrl_t CTRL_BUBBLE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1,
                                    exmem_en: 1'b1, memwb_en: 1'b1,
                                    ifid_flush: 1'b0, idex_flush: 1'b1,
                                    memwb_flush: 1'b0};

  // Instruction fetch not ready: bubble into IF/ID, downstream keeps going
  localparam ctrl_t CTRL_FETCH_WAIT = '{pc_en: 1'b0, ifid_en: 1'b1, idex_en: 1'b1,
                                        exmem_en: 1'b1, memwb_en: 1'b1,
                                        ifid_flush: 1'b1, idex_flush: 1'b0,
                                        memwb_flush: 1'b0};

  // Halted core: everything held, no flushes
  localparam ctrl_t CTRL_IDLE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0,
                                  exmem_en: 1'b0, memwb_en: 1'b0,
                                  ifid_flush: 1'b0, idex_flush: 1'b0,
                                  memwb_flush: 1'b0};

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  // Count up on inc, stick at all-ones, clear has priority
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 5-stage pipeline: merges hazard requests into
// per-register enables/flushes, tracks multi-cycle data waits and halt drain,
// and counts stall cycles and branch flushes.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int DRAIN_CYC   = DEF_DRAIN_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Need_Stall,
  input  logic             EX__Branch_Taken,
  input  logic             ID__Halt,
  input  logic             Imem_Ready,
  input  logic             EXmem__MemEnable,
  input  logic             Dmem_Ready,
  output logic             PC_En,
  output logic             IFid_En,
  output logic             IDex_En,
  output logic             EXmem_En,
  output logic             MEMwb_En,
  output logic             IFid_Flush,
  output logic             IDex_Flush,
  output logic             MEMwb_Flush,
  output logic             Halted,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

  state_e              state_reg, state_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [DRAIN_W-1:0]  drain_cnt_reg, drain_cnt_next;
  logic                mem_timeout_reg;
  ctrl_t               ctrl;
  logic                stall_inc;
  logic                flush_inc;
  logic                mem_busy;

  assign mem_busy = EXmem__MemEnable && !Dmem_Ready;

  // State and wait/drain counters; timeout flag is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= '0;
      drain_cnt_reg   <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      if ((state_reg == MEM_WAIT) && (wait_cnt_reg == WAIT_LIMIT)) begin
        mem_timeout_reg <= 1'b1;
      end
    end
  end

  // Next-state and wait/drain counter update
  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      RUN: begin
        if (mem_busy) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end else if (!EX__Branch_Taken && !Need_Stall && ID__Halt) begin
          state_next     = DRAIN;
          drain_cnt_next = '0;
        end
      end
      MEM_WAIT: begin
        if (Dmem_Ready) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg != WAIT_LIMIT) begin
          // Stop at the limit so the count can never wrap back to zero
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      DRAIN: begin
        // A data wait freezes EX..WB, so the drain count holds meanwhile
        if (!mem_busy) begin
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_next = HALTED;
          end else begin
            drain_cnt_next = drain_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = HALTED;
      end
    endcase
  end

  // Enable/flush vector and counter strobes, combinational in the same cycle
  always_comb begin
    ctrl      = CTRL_IDLE;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else begin
      case (state_reg)
        RUN: begin
          if (mem_busy) begin
            ctrl      = CTRL_FREEZE;
            stall_inc = 1'b1;
          end else if (EX__Branch_Taken) begin
            // Stall, fetch wait and halt are all on the wrong path here
            ctrl      = CTRL_BRANCH;
            flush_inc = 1'b1;
          end else if (Need_Stall) begin
            ctrl      = CTRL_BUBBLE;
            stall_inc = 1'b1;
          end else if (ID__Halt) begin
            ctrl = CTRL_BUBBLE;
          end else if (!Imem_Ready) begin
            ctrl      = CTRL_FETCH_WAIT;
            stall_inc = 1'b1;
          end else begin
            ctrl = CTRL_RUN;
          end
        end
        MEM_WAIT: begin
          if (Dmem_Ready) begin
            ctrl = CTRL_RUN;
          end else begin
            ctrl      = CTRL_FREEZE;
            stall_inc = 1'b1;
          end
        end
        DRAIN: begin
          ctrl = mem_busy ? CTRL_FREEZE : CTRL_BUBBLE;
        end
        default: begin
          ctrl = CTRL_IDLE;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (stall_inc),
    .cnt (Stall_Cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (flush_inc),
    .cnt (Flush_Cnt)
  );

  assign PC_En       = ctrl.pc_en;
  assign IFid_En     = ctrl.ifid_en;
  assign IDex_En     = ctrl.idex_en;
  assign EXmem_En    = ctrl.exmem_en;
  assign MEMwb_En    = ctrl.memwb_en;
  assign IFid_Flush  = ctrl.ifid_flush;
  assign IDex_Flush  = ctrl.idex_flush;
  assign MEMwb_Flush = ctrl.memwb_flush;
  assign Halted      = (state_reg == HALTED);
  assign Mem_Timeout = mem_timeout_reg;

endmodule
